// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit: steps each instruction through IF/ID/EXE/MEM/WB and decodes ALU/datapath controls.
// Outputs are combinational from state/op/funct/zero; j 2, beq/bne 3, ALU/sw 4, lw 5 cycles; no backpressure.
module mc_control_fsm #(
   parameter int STATE_W = 3
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   input  logic               zero,
   output logic               PCWre,
   output logic               IRWre,
   output logic [1:0]         PCSrc,
   output logic               ALUSrcA,
   output logic               ALUSrcB,
   output logic [3:0]         ALUOp,
   output logic               ExtSel,
   output logic               RegDst,
   output logic               RegWre,
   output logic               WrRegDSrc,
   output logic               mRD,
   output logic               mWR,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [STATE_W-1:0] {
      S_IF    = STATE_W'(0),
      S_ID    = STATE_W'(1),
      S_EXE_A = STATE_W'(2),
      S_EXE_B = STATE_W'(3),
      S_EXE_M = STATE_W'(4),
      S_MEM   = STATE_W'(5),
      S_WB    = STATE_W'(6),
      S_HALT  = STATE_W'(7)
   } state_t;

   typedef enum logic [2:0] {
      C_ALU, C_BR, C_LW, C_SW, C_J, C_ILL, C_HALT
   } cls_t;

   state_t     r_state;
   state_t     w_next;
   cls_t       w_cls;
   logic       w_rtype;
   logic [3:0] w_alu_op;
   logic       w_srca;
   logic       w_srcb;
   logic       w_ext;
   logic       w_ctl_en;
   logic       w_taken;

   always_comb begin
      w_cls    = C_ILL;
      w_rtype  = 1'b0;
      w_alu_op = 4'b0000;
      w_srca   = 1'b0;
      w_srcb   = 1'b0;
      w_ext    = 1'b0;
      case (op)
         6'b000000: begin
            w_cls   = C_ALU;
            w_rtype = 1'b1;
            case (funct)
               6'b100000: w_alu_op = 4'b0000;
               6'b100010: w_alu_op = 4'b0001;
               6'b101011: w_alu_op = 4'b0010;
               6'b101010: w_alu_op = 4'b0011;
               6'b000000: begin
                  w_alu_op = 4'b0100;
                  w_srca   = 1'b1;
               end
               6'b100101: w_alu_op = 4'b0101;
               6'b100100: w_alu_op = 4'b0110;
               6'b100110: w_alu_op = 4'b0111;
               6'b011000: w_alu_op = 4'b1000;
               6'b011010: w_alu_op = 4'b1001;
               default: begin
                  w_cls   = C_ILL;
                  w_rtype = 1'b0;
               end
            endcase
         end
         6'b001000: begin w_cls = C_ALU; w_alu_op = 4'b0000; w_srcb = 1'b1; w_ext = 1'b1; end
         6'b001010: begin w_cls = C_ALU; w_alu_op = 4'b0011; w_srcb = 1'b1; w_ext = 1'b1; end
         6'b001100: begin w_cls = C_ALU; w_alu_op = 4'b0110; w_srcb = 1'b1; end
         6'b001101: begin w_cls = C_ALU; w_alu_op = 4'b0101; w_srcb = 1'b1; end
         6'b001110: begin w_cls = C_ALU; w_alu_op = 4'b0111; w_srcb = 1'b1; end
         6'b100011: begin w_cls = C_LW;  w_srcb = 1'b1; w_ext = 1'b1; end
         6'b101011: begin w_cls = C_SW;  w_srcb = 1'b1; w_ext = 1'b1; end
         6'b000100,
         6'b000101: begin w_cls = C_BR;  w_alu_op = 4'b0001; w_ext = 1'b1; end
         6'b000010: w_cls = C_J;
         6'b111111: w_cls = C_HALT;
         default:   w_cls = C_ILL;
      endcase
   end

   assign w_ctl_en = (w_cls == C_ALU) || (w_cls == C_BR) || (w_cls == C_LW) || (w_cls == C_SW);
   assign w_taken  = (op == 6'b000100) ? zero : ~zero;

   always_ff @(posedge CLK) begin
      if (Reset) r_state <= S_IF;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      PCSrc     = 2'b00;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = 4'b0000;
      ExtSel    = 1'b0;
      RegDst    = 1'b0;
      RegWre    = 1'b0;
      WrRegDSrc = 1'b0;
      mRD       = 1'b0;
      mWR       = 1'b0;
      // ALU controls held constant from ID through WB so the ALU result does not glitch
      if (r_state != S_IF && r_state != S_HALT && w_ctl_en) begin
         ALUSrcA = w_srca;
         ALUSrcB = w_srcb;
         ALUOp   = w_alu_op;
         ExtSel  = w_ext;
      end
      case (r_state)
         S_IF: begin
            IRWre  = 1'b1;
            w_next = S_ID;
         end
         S_ID: begin
            case (w_cls)
               C_ALU:       w_next = S_EXE_A;
               C_BR:        w_next = S_EXE_B;
               C_LW, C_SW:  w_next = S_EXE_M;
               C_HALT:      w_next = S_HALT;
               C_J: begin
                  PCWre  = 1'b1;
                  PCSrc  = 2'b10;
                  w_next = S_IF;
               end
               default: begin
                  PCWre  = 1'b1;
                  w_next = S_IF;
               end
            endcase
         end
         S_EXE_A: w_next = S_WB;
         S_EXE_B: begin
            PCWre  = 1'b1;
            PCSrc  = w_taken ? 2'b01 : 2'b00;
            w_next = S_IF;
         end
         S_EXE_M: w_next = S_MEM;
         S_MEM: begin
            if (w_cls == C_LW) begin
               mRD    = 1'b1;
               w_next = S_WB;
            end else begin
               mWR    = 1'b1;
               PCWre  = 1'b1;
               w_next = S_IF;
            end
         end
         S_WB: begin
            RegWre    = 1'b1;
            RegDst    = w_rtype;
            WrRegDSrc = (w_cls == C_LW);
            PCWre     = 1'b1;
            w_next    = S_IF;
         end
         S_HALT:  w_next = S_HALT;
         default: w_next = S_IF;
      endcase
   end

   assign state = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed vector table, multi-cycle corner sequences and a randomized run
// compared per cycle against an instruction-level reference model.
module tb_mc_control_fsm;

   localparam int K_R = 0, K_I = 1, K_BR = 2, K_LW = 3, K_SW = 4, K_J = 5, K_ILL = 6, K_HALT = 7;

   logic       CLK = 1'b0;
   logic       Reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       PCWre, IRWre, ALUSrcA, ALUSrcB, ExtSel, RegDst, RegWre, WrRegDSrc, mRD, mWR;
   logic [1:0] PCSrc;
   logic [3:0] ALUOp;
   logic [2:0] state;

   int checks   = 0;
   int failures = 0;

   mc_control_fsm #(.STATE_W(3)) dut (
      .CLK(CLK), .Reset(Reset), .op(op), .funct(funct), .zero(zero),
      .PCWre(PCWre), .IRWre(IRWre), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .ExtSel(ExtSel), .RegDst(RegDst), .RegWre(RegWre),
      .WrRegDSrc(WrRegDSrc), .mRD(mRD), .mWR(mWR), .state(state)
   );

   always #5 CLK = ~CLK;

   // {PCWre,IRWre,PCSrc,ALUSrcA,ALUSrcB,ALUOp,ExtSel,RegDst,RegWre,WrRegDSrc,mRD,mWR,state}
   wire [18:0] w_dut = {PCWre, IRWre, PCSrc, ALUSrcA, ALUSrcB, ALUOp, ExtSel,
                        RegDst, RegWre, WrRegDSrc, mRD, mWR, state};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic void dec(input logic [5:0] o, input logic [5:0] f, output int kind,
                               output logic [3:0] aop, output logic sa, output logic sb, output logic ex);
      kind = K_ILL; aop = 4'd0; sa = 1'b0; sb = 1'b0; ex = 1'b0;
      case (o)
         6'd0: begin
            kind = K_R;
            case (f)
               6'b100000: aop = 4'd0;
               6'b100010: aop = 4'd1;
               6'b101011: aop = 4'd2;
               6'b101010: aop = 4'd3;
               6'b000000: begin aop = 4'd4; sa = 1'b1; end
               6'b100101: aop = 4'd5;
               6'b100100: aop = 4'd6;
               6'b100110: aop = 4'd7;
               6'b011000: aop = 4'd8;
               6'b011010: aop = 4'd9;
               default:   kind = K_ILL;
            endcase
            if (kind == K_ILL) begin aop = 4'd0; sa = 1'b0; end
         end
         6'd8:  begin kind = K_I;  aop = 4'd0; sb = 1'b1; ex = 1'b1; end
         6'd10: begin kind = K_I;  aop = 4'd3; sb = 1'b1; ex = 1'b1; end
         6'd12: begin kind = K_I;  aop = 4'd6; sb = 1'b1; end
         6'd13: begin kind = K_I;  aop = 4'd5; sb = 1'b1; end
         6'd14: begin kind = K_I;  aop = 4'd7; sb = 1'b1; end
         6'd35: begin kind = K_LW; sb = 1'b1; ex = 1'b1; end
         6'd43: begin kind = K_SW; sb = 1'b1; ex = 1'b1; end
         6'd4, 6'd5: begin kind = K_BR; aop = 4'd1; ex = 1'b1; end
         6'd2:  kind = K_J;
         6'd63: kind = K_HALT;
         default: kind = K_ILL;
      endcase
   endfunction

   function automatic int len_of(input int kind);
      case (kind)
         K_R, K_I, K_SW: return 4;
         K_BR:           return 3;
         K_LW:           return 5;
         K_J, K_ILL:     return 2;
         default:        return 1000;
      endcase
   endfunction

   // Expected outputs for cycle k (0 = fetch) of an instruction, from its class and total latency.
   function automatic logic [18:0] model(input logic [5:0] o, input logic [5:0] f, input logic z, input int k);
      int kind, n;
      logic [3:0] aop;
      logic sa, sb, ex, pcw, irw, rw, rd, wsrc, mr, mw;
      logic [1:0] ps;
      logic [2:0] st;
      dec(o, f, kind, aop, sa, sb, ex);
      n = len_of(kind);
      if (k == 0) st = 3'd0;
      else if (k == 1) st = 3'd1;
      else case (kind)
         K_R, K_I:   st = (k == 2) ? 3'd2 : 3'd6;
         K_BR:       st = 3'd3;
         K_LW, K_SW: st = (k == 2) ? 3'd4 : (k == 3) ? 3'd5 : 3'd6;
         default:    st = 3'd7;
      endcase
      irw = (k == 0);
      pcw = (kind != K_HALT) && (k == n - 1);
      ps  = 2'b00;
      if (kind == K_J && k == 1) ps = 2'b10;
      else if (kind == K_BR && k == 2 && ((o == 6'd4 && z) || (o == 6'd5 && !z))) ps = 2'b01;
      if (!(k >= 1 && (kind inside {K_R, K_I, K_BR, K_LW, K_SW}))) begin
         aop = 4'd0; sa = 1'b0; sb = 1'b0; ex = 1'b0;
      end
      rw   = pcw && (kind inside {K_R, K_I, K_LW});
      rd   = rw && (kind == K_R);
      wsrc = rw && (kind == K_LW);
      mr   = (kind == K_LW) && (k == 3);
      mw   = (kind == K_SW) && (k == 3);
      return {pcw, irw, ps, sa, sb, aop, ex, rd, rw, wsrc, mr, mw, st};
   endfunction

   // Runs one instruction starting in IF; entered and left 1 time unit after a rising edge.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input bit rand_zero, output logic [18:0] last_vec);
      int kind, n;
      logic [3:0] aop;
      logic sa, sb, ex;
      dec(o, f, kind, aop, sa, sb, ex);
      n = len_of(kind);
      op = o; funct = f; zero = z;
      for (int k = 0; k < n; k++) begin
         if (rand_zero) zero = 1'($urandom_range(0, 1));
         #1;
         chk($sformatf("step op=%0d funct=%0d k=%0d", o, f, k), 32'(w_dut), 32'(model(o, f, zero, k)));
         last_vec = w_dut;
         @(posedge CLK); #1;
      end
      chk("end_state", 32'(state), 32'd0);
   endtask

   typedef struct {
      logic [5:0] op;
      logic [5:0] funct;
      logic       zero;
      logic [3:0] aop;
      logic       sa;
      logic       sb;
      logic       ex;
      logic [1:0] pcsrc;
   } vec_t;

   vec_t tbl[$];
   logic [18:0] lv;
   logic [5:0] op_pool[13] = '{6'd0, 6'd0, 6'd0, 6'd8, 6'd10, 6'd12, 6'd13, 6'd14, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2};
   logic [5:0] fn_pool[10] = '{6'd32, 6'd34, 6'd43, 6'd42, 6'd0, 6'd37, 6'd36, 6'd38, 6'd24, 6'd26};

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] ro, rf;
      tbl.push_back('{6'd0,  6'b100000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00});
      tbl.push_back('{6'd0,  6'b100010, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 2'b00});
      tbl.push_back('{6'd0,  6'b000000, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 2'b00});
      tbl.push_back('{6'd0,  6'b011010, 1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, 2'b00});
      tbl.push_back('{6'd13, 6'b000000, 1'b0, 4'b0101, 1'b0, 1'b1, 1'b0, 2'b00});
      tbl.push_back('{6'd10, 6'b000000, 1'b0, 4'b0011, 1'b0, 1'b1, 1'b1, 2'b00});
      tbl.push_back('{6'd35, 6'b000000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b00});
      tbl.push_back('{6'd43, 6'b000000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b00});
      tbl.push_back('{6'd4,  6'b000000, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 2'b01});
      tbl.push_back('{6'd4,  6'b000000, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 2'b00});
      tbl.push_back('{6'd5,  6'b000000, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 2'b01});
      tbl.push_back('{6'd5,  6'b000000, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1, 2'b00});
      tbl.push_back('{6'd2,  6'b000000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b10});
      tbl.push_back('{6'd0,  6'b111111, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00});
      tbl.push_back('{6'd21, 6'b100000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'b00});

      Reset = 1'b1; op = 6'd0; funct = 6'b100000; zero = 1'b0;
      repeat (2) @(posedge CLK);
      #1 Reset = 1'b0;
      #1;
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_IRWre", 32'(IRWre), 32'd1);
      chk("reset_PCWre", 32'(PCWre), 32'd0);
      chk("reset_RegWre", 32'(RegWre), 32'd0);

      foreach (tbl[i]) begin
         run_instr(tbl[i].op, tbl[i].funct, tbl[i].zero, 1'b0, lv);
         chk($sformatf("tbl%0d_PCWre", i), 32'(lv[18]), 32'd1);
         chk($sformatf("tbl%0d_PCSrc", i), 32'(lv[16:15]), 32'(tbl[i].pcsrc));
         chk($sformatf("tbl%0d_ALUSrcA", i), 32'(lv[14]), 32'(tbl[i].sa));
         chk($sformatf("tbl%0d_ALUSrcB", i), 32'(lv[13]), 32'(tbl[i].sb));
         chk($sformatf("tbl%0d_ALUOp", i), 32'(lv[12:9]), 32'(tbl[i].aop));
         chk($sformatf("tbl%0d_ExtSel", i), 32'(lv[8]), 32'(tbl[i].ex));
      end

      // lw write-back controls in its final cycle
      run_instr(6'd35, 6'd0, 1'b0, 1'b0, lv);
      chk("lw_wb_state", 32'(lv[2:0]), 32'd6);
      chk("lw_wb_RegDst", 32'(lv[7]), 32'd0);
      chk("lw_wb_WrRegDSrc", 32'(lv[5]), 32'd1);

      // Reset during EXE_A of an add abandons it without a register write
      op = 6'd0; funct = 6'b100000; zero = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1 chk($sformatf("abort_k%0d", k), 32'(w_dut), 32'(model(op, funct, zero, k)));
         if (k == 2) Reset = 1'b1;
         @(posedge CLK); #1;
      end
      chk("abort_state", 32'(state), 32'd0);
      chk("abort_RegWre", 32'(RegWre), 32'd0);
      Reset = 1'b0;
      run_instr(6'd0, 6'b100000, 1'b0, 1'b0, lv);

      // HALT holds with every enable low, then Reset releases it
      op = 6'd63; funct = 6'd0; zero = 1'b0;
      for (int k = 0; k < 12; k++) begin
         #1 chk($sformatf("halt_k%0d", k), 32'(w_dut), 32'(model(op, funct, zero, k)));
         @(posedge CLK); #1;
      end
      Reset = 1'b1;
      #1 chk("halt_hold", 32'(state), 32'd7);
      @(posedge CLK); #1;
      chk("halt_reset_state", 32'(state), 32'd0);
      chk("halt_reset_IRWre", 32'(IRWre), 32'd1);
      Reset = 1'b0;

      for (int i = 0; i < 400; i++) begin
         ro = op_pool[$urandom_range(0, 12)];
         if ($urandom_range(0, 7) == 0) ro = 6'($urandom);
         if (ro == 6'd63) ro = 6'd62;
         rf = fn_pool[$urandom_range(0, 9)];
         if ($urandom_range(0, 5) == 0) rf = 6'($urandom);
         run_instr(ro, rf, 1'($urandom_range(0, 1)), 1'b1, lv);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle control unit directly upstream of the ALU.
- Sequences each instruction through IF/ID/EXE/MEM/WB states.
- Decodes opcode/funct into ALUSrcA, ALUSrcB and ALUOp for the ALU, plus datapath enables.
- Consumes the ALU's zero flag to resolve beq/bne.

Parameters:
- STATE_W, 3, width of state register and state output.

Ports:
- CLK  input  1  system clock, rising edge
- Reset  input  1  synchronous, active-high reset
- op  input  6  instruction[31:26] from the instruction register
- funct  input  6  instruction[5:0] from the instruction register
- zero  input  1  ALU zero flag
- PCWre  output  1  PC write enable
- IRWre  output  1  instruction register write enable
- PCSrc  output  2  next PC select: 00 PC+4, 01 branch target, 10 jump target
- ALUSrcA  output  1  ALU A select: 0 = ReadData1, 1 = sa
- ALUSrcB  output  1  ALU B select: 0 = ReadData2, 1 = extended immediate
- ALUOp  output  4  ALU operation code
- ExtSel  output  1  0 = zero-extend, 1 = sign-extend
- RegDst  output  1  write register: 1 = rd, 0 = rt
- RegWre  output  1  register file write enable
- WrRegDSrc  output  1  write-back data: 0 = ALU result, 1 = memory data
- mRD  output  1  data memory read enable
- mWR  output  1  data memory write enable
- state  output  3  current state, for debug

Behaviour:
- Clocking: single clock CLK. Reset is synchronous and active-high. Reset forces state to IF (000) on the next rising edge, including mid-instruction; any partial instruction is abandoned.
- State encoding: IF=000, ID=001, EXE_A=010, EXE_B=011, EXE_M=100, MEM=101, WB=110, HALT=111.
- Output timing: outputs are combinational from state, op and funct. Every enable is 0 outside the states listed below.
- Reset-state outputs (IF): IRWre=1; all other 1-bit outputs 0; PCSrc=00; ALUOp=0000.
- Transitions:
  - IF -> ID always.
  - ID -> EXE_A for R-type, addi, andi, ori, xori, slti.
  - ID -> EXE_B for beq, bne.
  - ID -> EXE_M for lw, sw.
  - ID -> IF for j and for illegal op/funct (illegal is a NOP).
  - ID -> HALT for op 111111.
  - EXE_A -> WB.
  - EXE_B -> IF.
  - EXE_M -> MEM.
  - MEM -> WB for lw; MEM -> IF for sw.
  - WB -> IF.
  - HALT -> HALT until Reset.
- Instruction latencies: j 2 cycles; beq/bne 3; R-type/I-type ALU and sw 4; lw 5.
- R-type decode (op 000000), funct -> ALUOp:
  - add 100000 -> 0000
  - sub 100010 -> 0001
  - sltu 101011 -> 0010
  - slt 101010 -> 0011
  - sll 000000 -> 0100, with ALUSrcA=1
  - or 100101 -> 0101
  - and 100100 -> 0110
  - xor 100110 -> 0111
  - mul 011000 -> 1000
  - div 011010 -> 1001
- I-type decode, op -> ALUOp, ExtSel:
  - addi 001000 -> 0000, ExtSel=1
  - slti 001010 -> 0011, ExtSel=1
  - andi 001100 -> 0110, ExtSel=0
  - ori 001101 -> 0101, ExtSel=0
  - xori 001110 -> 0111, ExtSel=0
  - lw 100011 / sw 101011 -> 0000, ExtSel=1
  - beq 000100 / bne 000101 -> 0001, ALUSrcB=0, ExtSel=1
- ALUSrcB=1 for all I-type ALU ops and for lw/sw.
- ALU control hold: ALUSrcA, ALUSrcB, ALUOp and ExtSel are driven to the decoded values in ID, EXE_*, MEM and WB. They must stay stable from EXE through WB, because the ALU recomputes on any change of its inputs.
- Register write (WB only): RegWre=1. RegDst=1 for R-type, else 0. WrRegDSrc=1 for lw only.
- Memory: mRD=1 in MEM for lw; mWR=1 in MEM for sw.
- PC update: PCWre=1 for exactly one cycle per instruction, in the final state:
  - ID for j (PCSrc=10)
  - EXE_B for branches
  - MEM for sw
  - WB otherwise
  - ID for illegal instructions
- Branch resolution: in EXE_B, PCSrc=01 if (beq & zero) or (bne & ~zero), else 00. Zero is sampled combinationally in that cycle.
- HALT: all enables 0, including PCWre and IRWre.
- Simultaneous Reset and HALT: Reset wins.

Test Plan:
- Reset high 2 cycles then low -> state=000, IRWre=1, PCWre=0, RegWre=0.
- add (op 0, funct 100000) -> states 000,001,010,110,000; ALUOp=0000, ALUSrcB=0, RegDst=1; RegWre=1 and PCWre=1 only in cycle 4.
- lw (op 100011) -> 5-cycle sequence ending in WB; mRD=1 only in MEM; ALUSrcB=1, ExtSel=1, WrRegDSrc=1, RegDst=0 in WB.
- beq with zero=1 -> EXE_B has PCSrc=01, PCWre=1; repeat with zero=0 -> PCSrc=00; bne with zero=0 -> PCSrc=01.
- sll (funct 000000) -> ALUSrcA=1, ALUOp=0100; ori -> ALUOp=0101, ExtSel=0; j -> PCWre=1, PCSrc=10 in ID, back to IF in 2 cycles.
- op 111111 -> HALT held 10 cycles with all enables 0; assert Reset during EXE_A of an add -> next state 000 and RegWre never asserted.
